// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the register ROM and issues one SCCB write per entry.
// 16'hFFF0 entries insert a fixed delay and 16'hFFFF ends the table.
module ov7670_config_seq #(
  parameter logic [7:0]  CAM_ID       = 8'h42,
  parameter int unsigned DELAY_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [7:0]  sccb_id,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  output logic        sccb_start,
  input  logic        sccb_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  wr_count
);

  localparam int unsigned CntW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CntW-1:0] DelayLoad = CntW'(DELAY_CYCLES - 1);
  localparam logic [15:0] EntryEnd   = 16'hFFFF;
  localparam logic [15:0] EntryDelay = 16'hFFF0;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StSend, StWait, StDelay, StNext, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] delay_cnt;
  logic            accept, latch_entry, issue, load_delay, advance;

  assign sccb_id = CAM_ID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (rom_data == EntryEnd) begin
          state_d = StDone;
        end else if (rom_data == EntryDelay) begin
          state_d = StDelay;
        end else begin
          state_d = StSend;
        end
      end
      StSend:   if (sccb_ready) state_d = StWait;
      // sccb_start is high only in the first WAIT cycle, which masks the master's late ready drop
      StWait:   if (!sccb_start && sccb_ready) state_d = StNext;
      StDelay:  if (delay_cnt == '0) state_d = StNext;
      StNext:   state_d = (rom_addr == 8'hFF) ? StDone : StFetch;
      StDone:   if (start) state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle) && (state_q != StDone);
    done        = (state_q == StDone);
    accept      = 1'b0;
    latch_entry = 1'b0;
    issue       = 1'b0;
    load_delay  = 1'b0;
    advance     = 1'b0;
    case (state_q)
      StIdle:   accept = start;
      StDecode: begin
        if (rom_data == EntryDelay) begin
          load_delay = 1'b1;
        end else if (rom_data != EntryEnd) begin
          latch_entry = 1'b1;
        end
      end
      StSend:   issue = sccb_ready;
      StNext:   advance = (rom_addr != 8'hFF);
      StDone:   accept = start;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr   <= 8'h00;
      sccb_reg   <= 8'h00;
      sccb_val   <= 8'h00;
      sccb_start <= 1'b0;
      wr_count   <= 8'h00;
      delay_cnt  <= '0;
    end else begin
      sccb_start <= issue;
      if (accept) begin
        rom_addr <= 8'h00;
      end else if (advance) begin
        rom_addr <= rom_addr + 8'd1;
      end
      if (latch_entry) begin
        sccb_reg <= rom_data[15:8];
        sccb_val <= rom_data[7:0];
      end
      if (accept) begin
        wr_count <= 8'h00;
      end else if (issue && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end
      if (load_delay) begin
        delay_cnt <= DelayLoad;
      end else if ((state_q == StDelay) && (delay_cnt != '0)) begin
        delay_cnt <= delay_cnt - CntW'(1);
      end
    end
  end

endmodule
